// File: rtl/re_cam_pkg.sv
// Shared types and constants for the 2x2 RE camera pixel-side capture logic.
package re_cam_pkg;

   typedef enum logic [1:0] {IDLE, EXPOSE, READ, EMIT} state_t;

   localparam int PIX_W_DEF     = 8;
   localparam int EXP_CNT_W_DEF = 5;

   localparam int ROW0 = 0;
   localparam int ROW1 = 1;

   // Word offsets of each pixel inside pix_out, in units of PIX_W.
   localparam int P00_OFF = 0;
   localparam int P01_OFF = 1;
   localparam int P10_OFF = 2;
   localparam int P11_OFF = 3;

endpackage

// File: rtl/re_edge_det.sv
// Registered rise/fall detector; level is the one-cycle-delayed input copy.
module re_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic level,
   output logic rise,
   output logic fall
);

   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         level <= sig;
         rise  <= sig & ~level;
         fall  <= ~sig & level;
      end
   end

endmodule

// File: rtl/re_frame_capture.sv
// Pixel-side responder: measures exposure, captures two ADC rows per frame and
// hands the assembled 2x2 frame downstream over valid/ready.
module re_frame_capture
   import re_cam_pkg::*;
#(
   parameter int PIX_W     = PIX_W_DEF,
   parameter int EXP_CNT_W = EXP_CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 erase,
   input  logic                 expose,
   input  logic                 NRE1,
   input  logic                 NRE2,
   input  logic                 adc,
   input  logic [PIX_W-1:0]     adc_col0,
   input  logic [PIX_W-1:0]     adc_col1,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [4*PIX_W-1:0]   pix_out,
   output logic [EXP_CNT_W-1:0] exp_cycles,
   output logic                 busy,
   output logic                 proto_err,
   output logic                 overrun
);

   state_t state, state_n;

   logic exp_lvl, exp_rise, exp_fall;
   logic adc_lvl_unused, adc_rise_unused, adc_fall;

   // Row selects and column data are delayed to line up with the registered adc fall.
   logic                 nre1_q, nre2_q;
   logic [2*PIX_W-1:0]   col_q;

   logic [1:0][2*PIX_W-1:0] row_buf;
   logic [1:0]              row_done, done_n;
   logic [EXP_CNT_W-1:0]    cnt;

   logic clr_buf, cnt_clr, cnt_inc, exp_latch, cap0, cap1, err, emit;

   re_edge_det u_exp_det (
      .clk(clk), .reset(reset), .sig(expose),
      .level(exp_lvl), .rise(exp_rise), .fall(exp_fall)
   );

   re_edge_det u_adc_det (
      .clk(clk), .reset(reset), .sig(adc),
      .level(adc_lvl_unused), .rise(adc_rise_unused), .fall(adc_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      clr_buf   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      exp_latch = 1'b0;
      cap0      = 1'b0;
      cap1      = 1'b0;
      err       = 1'b0;
      emit      = 1'b0;
      done_n    = row_done;
      case (state)
         IDLE: begin
            if (erase) clr_buf = 1'b1;
            if (exp_rise) begin
               cnt_clr = 1'b1;
               state_n = EXPOSE;
            end
            if (adc_fall) err = 1'b1;
         end
         EXPOSE: begin
            if (adc_fall) err = 1'b1;
            if (erase) begin
               clr_buf = 1'b1;
               state_n = IDLE;
            end else begin
               if (exp_lvl) cnt_inc = 1'b1;
               if (exp_fall) begin
                  exp_latch = 1'b1;
                  state_n   = READ;
               end
            end
         end
         READ: begin
            if (erase) begin
               clr_buf = 1'b1;
               state_n = IDLE;
            end else begin
               if (exp_rise) err = 1'b1;
               if (adc_fall) begin
                  if (nre1_q ^ nre2_q) begin
                     cap0         = ~nre1_q;
                     cap1         = ~nre2_q;
                     done_n[ROW0] = row_done[ROW0] | ~nre1_q;
                     done_n[ROW1] = row_done[ROW1] | ~nre2_q;
                     if (done_n == 2'b11) state_n = EMIT;
                  end else begin
                     err = 1'b1;
                  end
               end
            end
         end
         EMIT: begin
            emit    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nre1_q      <= 1'b0;
         nre2_q      <= 1'b0;
         col_q       <= '0;
         row_buf     <= '0;
         row_done    <= '0;
         cnt         <= '0;
         exp_cycles  <= '0;
         proto_err   <= 1'b0;
         frame_valid <= 1'b0;
         pix_out     <= '0;
         overrun     <= 1'b0;
      end else begin
         nre1_q    <= NRE1;
         nre2_q    <= NRE2;
         col_q     <= {adc_col1, adc_col0};
         proto_err <= err;

         if (cnt_clr)                      cnt <= EXP_CNT_W'(1);
         else if (cnt_inc && (cnt != '1))  cnt <= cnt + 1'b1;
         if (exp_latch) exp_cycles <= cnt;

         if (clr_buf) begin
            row_buf  <= '0;
            row_done <= '0;
         end else if (emit) begin
            row_done <= '0;
         end else begin
            if (cap0) row_buf[ROW0] <= col_q;
            if (cap1) row_buf[ROW1] <= col_q;
            row_done <= done_n;
         end

         // A pending frame is only replaced when it is consumed on this very edge.
         if (emit && (!frame_valid || frame_ready)) begin
            pix_out     <= {row_buf[ROW1], row_buf[ROW0]};
            frame_valid <= 1'b1;
         end else begin
            if (emit) overrun <= 1'b1;
            if (frame_valid && frame_ready) frame_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_re_frame_capture.sv
// Self-checking bench for re_frame_capture: table-driven frames plus corner sequences.
module tb_re_frame_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        erase = 1'b0, expose = 1'b0, NRE1 = 1'b1, NRE2 = 1'b1, adc = 1'b0;
   logic [7:0]  adc_col0 = '0, adc_col1 = '0;
   logic        frame_ready = 1'b0;
   logic        frame_valid, busy, proto_err, overrun;
   logic [31:0] pix_out;
   logic [4:0]  exp_cycles;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   typedef struct {
      int         len;
      logic [7:0] a0, a1, b0, b1;
      logic [31:0] pix;
      logic [4:0] expc;
   } vec_t;
   vec_t tbl[5];

   re_frame_capture dut (
      .clk(clk), .reset(reset), .erase(erase), .expose(expose),
      .NRE1(NRE1), .NRE2(NRE2), .adc(adc),
      .adc_col0(adc_col0), .adc_col1(adc_col1),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .pix_out(pix_out), .exp_cycles(exp_cycles), .busy(busy),
      .proto_err(proto_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Record every frame that crosses the handshake.
   always @(negedge clk)
      if (!reset && frame_valid && frame_ready) got_q.push_back(pix_out);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_erase();
      erase = 1'b1; tick(); erase = 1'b0; tick();
   endtask

   task automatic expose_for(input int n);
      expose = 1'b1;
      repeat (n) tick();
      expose = 1'b0;
      repeat (3) tick();
   endtask

   task automatic capture(input logic n1, input logic n2, input logic [7:0] c0, input logic [7:0] c1);
      NRE1 = n1; NRE2 = n2; adc_col0 = c0; adc_col1 = c1;
      adc = 1'b1; tick();
      adc = 1'b0; tick();
      NRE1 = 1'b1; NRE2 = 1'b1;
   endtask

   task automatic err_pulse(input string name);
      chk({name, "_pre"}, {31'd0, proto_err}, 32'd0);
      tick();
      chk({name, "_hi"}, {31'd0, proto_err}, 32'd1);
      tick();
      chk({name, "_lo"}, {31'd0, proto_err}, 32'd0);
   endtask

   task automatic full_frame(input int len, input logic [7:0] a0, a1, b0, b1);
      pulse_erase();
      expose_for(len);
      capture(1'b0, 1'b1, a0, a1);
      capture(1'b1, 1'b0, b0, b1);
   endtask

   task automatic ack();
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
   endtask

   task automatic drain(input string name);
      chk({name, "_sb_cnt"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk({name, "_sb"}, got_q.pop_front(), exp_q.pop_front());
   endtask

   initial begin
      tbl[0] = '{11, 8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 5'd11};
      tbl[1] = '{40, 8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 5'd31};
      tbl[2] = '{1,  8'hA5, 8'h5A, 8'hFF, 8'h00, 32'h00FF5AA5, 5'd1};
      tbl[3] = '{31, 8'h10, 8'h20, 8'h30, 8'h40, 32'h40302010, 5'd31};
      tbl[4] = '{32, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE, 5'd31};

      repeat (2) tick();
      reset = 1'b0;
      chk("rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst_pix", pix_out, 32'd0);
      chk("rst_exp", {27'd0, exp_cycles}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         full_frame(tbl[i].len, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1);
         tick();
         chk($sformatf("v%0d_lat1", i), {31'd0, frame_valid}, 32'd0);
         tick();
         chk($sformatf("v%0d_lat2", i), {31'd0, frame_valid}, 32'd1);
         chk($sformatf("v%0d_exp", i), {27'd0, exp_cycles}, {27'd0, tbl[i].expc});
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
         exp_q.push_back(tbl[i].pix);
         ack();
         chk($sformatf("v%0d_clr", i), {31'd0, frame_valid}, 32'd0);
         drain($sformatf("v%0d", i));
      end

      // Bad row selects in READ leave the captured row intact.
      pulse_erase();
      expose_for(3);
      capture(1'b0, 1'b1, 8'hAA, 8'hBB);
      tick();
      capture(1'b0, 1'b0, 8'hEE, 8'hEE);
      err_pulse("err_both_low");
      capture(1'b1, 1'b1, 8'hEE, 8'hEE);
      err_pulse("err_both_high");
      repeat (3) tick();
      chk("err_nofrm", {31'd0, frame_valid}, 32'd0);
      chk("err_busy", {31'd0, busy}, 32'd1);
      capture(1'b1, 1'b0, 8'hCC, 8'hDD);
      repeat (2) tick();
      chk("err_frm", {31'd0, frame_valid}, 32'd1);
      exp_q.push_back(32'hDDCCBBAA);
      ack();
      drain("err");
      capture(1'b0, 1'b1, 8'h12, 8'h34);
      err_pulse("err_idle");
      repeat (3) tick();
      chk("err_idle_nofrm", {31'd0, frame_valid}, 32'd0);

      // Overrun: B arrives while A is still pending.
      full_frame(4, 8'h01, 8'h23, 8'h45, 8'h67);
      repeat (2) tick();
      chk("ovr_a_valid", {31'd0, frame_valid}, 32'd1);
      chk("ovr_a_flag", {31'd0, overrun}, 32'd0);
      full_frame(5, 8'h89, 8'hAB, 8'hCD, 8'hEF);
      repeat (2) tick();
      chk("ovr_flag", {31'd0, overrun}, 32'd1);
      chk("ovr_keep", pix_out, 32'h67452301);
      chk("ovr_valid", {31'd0, frame_valid}, 32'd1);
      exp_q.push_back(32'h67452301);
      ack();
      chk("ovr_clr", {31'd0, frame_valid}, 32'd0);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);
      drain("ovr");

      // Abort after row 0, then a clean frame.
      pulse_erase();
      expose_for(5);
      capture(1'b0, 1'b1, 8'h55, 8'h66);
      erase = 1'b1; tick(); erase = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (4) tick();
      chk("abort_nofrm", {31'd0, frame_valid}, 32'd0);
      full_frame(6, 8'h77, 8'h88, 8'h99, 8'hAA);
      repeat (2) tick();
      chk("abort_next_valid", {31'd0, frame_valid}, 32'd1);
      chk("abort_next_exp", {27'd0, exp_cycles}, 32'd6);
      exp_q.push_back(32'hAA998877);
      ack();
      drain("abort");

      // Reset mid-EXPOSE with a frame pending and overrun set.
      full_frame(3, 8'h0F, 8'h1E, 8'h2D, 8'h3C);
      repeat (2) tick();
      chk("rst2_pre_valid", {31'd0, frame_valid}, 32'd1);
      expose = 1'b1;
      repeat (3) tick();
      chk("rst2_pre_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1; expose = 1'b0;
      tick();
      reset = 1'b0;
      chk("rst2_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst2_pix", pix_out, 32'd0);
      chk("rst2_exp", {27'd0, exp_cycles}, 32'd0);
      chk("rst2_busy", {31'd0, busy}, 32'd0);
      chk("rst2_ovr", {31'd0, overrun}, 32'd0);
      chk("rst2_perr", {31'd0, proto_err}, 32'd0);

      chk("sb_left_exp", exp_q.size(), 32'd0);
      chk("sb_left_got", got_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/re_frame_capture.md
Name: re_frame_capture

Overview:
Pixel-side responder for the four-pixel (2x2) RE camera controller. It consumes the controller's erase, expose, NRE1, NRE2 and adc strobes and captures two parallel ADC column words per row conversion. It assembles a complete 2x2 frame and measures the exposure length in clocks. It hands the frame downstream over a valid/ready handshake and flags protocol violations and frame overruns.

Parameters:
PIX_W, 8, ADC word width per pixel.
EXP_CNT_W, 5, width of the measured-exposure counter; saturates at 2^EXP_CNT_W-1.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
erase  in  1  pixel erase strobe from controller.
expose  in  1  exposure window from controller.
NRE1  in  1  row 0 select, active low.
NRE2  in  1  row 1 select, active low.
adc  in  1  conversion strobe; data valid at its falling edge.
adc_col0  in  PIX_W  column 0 ADC result.
adc_col1  in  PIX_W  column 1 ADC result.
frame_valid  out  1  pix_out holds an unconsumed frame.
frame_ready  in  1  downstream accepts frame.
pix_out  out  4*PIX_W  {p11,p10,p01,p00}, with p<row><col>.
exp_cycles  out  EXP_CNT_W  clocks expose was high in the last exposure.
busy  out  1  high in any state other than IDLE.
proto_err  out  1  one-cycle pulse on a protocol violation.
overrun  out  1  sticky until reset; a completed frame was dropped.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Inputs are treated as synchronous to clk.
- reset=1 forces the following on the next edge, regardless of state:
  - state=IDLE.
  - frame_valid, pix_out, exp_cycles, proto_err, overrun, row buffer and row_done[1:0] all 0.
  - expose_q and adc_q (previous-cycle copies used for edge detection) all 0.
- Edge detection: rise = sig & ~sig_q; fall = ~sig & sig_q.
- States:
  - IDLE:
    - erase=1: clear row buffer and row_done.
    - expose rise: clear exposure counter, go to EXPOSE. A rise edge counts as 1 exposure cycle.
  - EXPOSE:
    - counter += 1 per clock with expose=1, saturating at all-ones.
    - expose fall: latch the counter into exp_cycles, go to READ.
  - READ: act on each adc fall:
    - NRE1=0, NRE2=1: store {adc_col1,adc_col0} into row 0, set row_done[0].
    - NRE2=0, NRE1=1: store into row 1, set row_done[1].
    - Both rows low or both high: proto_err=1 for one cycle, sample discarded.
    - A repeated row overwrites the stored value; no error.
    - When row_done becomes 2'b11: go to EMIT.
  - EMIT (one cycle):
    - frame_valid=0, or frame_valid & frame_ready in this cycle: load pix_out, set frame_valid.
    - Otherwise: keep old frame, set overrun, drop new frame.
    - In all cases clear row_done and go to IDLE.
- Frame latency: frame_valid is first high 2 cycles after the clock edge that sampled the completing adc fall.
- Handshake:
  - frame_valid stays high and pix_out is stable until a cycle with frame_ready=1. frame_valid clears on that edge unless EMIT reloads it on the same edge.
  - frame_ready is ignored while frame_valid=0.
- Out-of-state events:
  - erase=1 in EXPOSE or READ: abort, clear buffer and row_done, return to IDLE. No frame is emitted and exp_cycles is unchanged.
  - adc fall in IDLE or EXPOSE: proto_err pulse, no capture.
  - expose rise in READ: proto_err pulse, ignored.
- Simultaneous erase and expose rise in IDLE: erase clears, then enter EXPOSE in the same edge.
- busy = (state != IDLE).

Decomposition:
- Package re_cam_pkg holds:
  - state enum {IDLE, EXPOSE, READ, EMIT};
  - PIX_W and EXP_CNT_W defaults;
  - row index constants ROW0=0, ROW1=1;
  - pix_out slice offsets.
- One sub-module, re_edge_det: registered rise/fall detector with synchronous reset. Instantiated for expose and adc.

Test Plan:
- Nominal: erase pulse, expose high 11 clocks. Then NRE1=0 with adc fall (col0=8'h11, col1=8'h22), then NRE2=0 with adc fall (8'h33, 8'h44). Required: exp_cycles=11, pix_out=32'h44332211, frame_valid 2 cycles after the second fall; it clears on frame_ready.
- Saturation: expose high 40 clocks with EXP_CNT_W=5 -> exp_cycles=31.
- Protocol errors: adc fall with NRE1=NRE2=0, with both =1, and in IDLE. Required: proto_err pulses three times, one cycle each. No frame is emitted; row_done is unchanged.
- Overrun: complete frame A (frame_ready held 0), then complete frame B with different data. Required: overrun=1, pix_out still equals A; after frame_ready, frame_valid=0.
- Abort: erase=1 after the row-0 capture in READ. Required: IDLE, busy=0, no frame_valid. The next full sequence yields a frame with correct data.
- Reset mid-EXPOSE and with frame_valid=1. Required: all outputs 0 on the next edge; overrun cleared.
